isp_cfg_sequencer: RTL

Frame-synchronous configuration controller for the ISP chain (Bayer NR -> demosaic -> CSC -> 2DNR -> YCbCr-to-RGB). A host writes shadow registers over a valid/ready port. The block commits them atomically to the active outputs only at a frame start, so a frame never sees mixed settings. It also tracks frame and line position from the input sync signals and reports status.

---
 rtl/isp_cfg_sequencer_if.sv | 26 ++
 rtl/isp_cfg_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// isp_cfg_sequencer_if
//
// Host configuration write port for the ISP configuration sequencer.
// A beat is accepted when cfg_valid and cfg_ready are both high on a rising
// clock edge.
//
// Signals:
//   cfg_valid  host -> sequencer  write request
//   cfg_ready  sequencer -> host  write may be accepted this cycle
//   cfg_addr   host -> sequencer  5-bit register address
//   cfg_wdata  host -> sequencer  8-bit write data
//
// Modports:
//   master  host side
//   slave   sequencer side
// ---------------------------------------------------------------------------
interface isp_cfg_sequencer_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_wdata;

  modport master (output cfg_valid, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/isp_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// isp_cfg_sequencer
//
// Frame-synchronous configuration controller for the ISP chain. The host
// writes shadow registers through the cfg port. The shadow set is copied to
// the active outputs only at a frame start, and only when a commit has been
// armed, so a frame never runs on a mix of old and new settings. The block
// also tracks frame and line position from the registered sync inputs.
//
// Optional feature macro: ISP_CFG_FRAME_CHECK_EN
//   When defined, line and pixel geometry is checked against IMG_VDISP and
//   IMG_HDISP, and mismatches set the sticky frame_err flag. Writing 1 to
//   bit 0 of register 0x15 clears the flag. When the macro is undefined,
//   frame_err is tied low and register 0x15 is ignored.
//
// Parameters:
//   IMG_HDISP        active pixels per line
//   IMG_VDISP        active lines per frame
//
// Ports:
//   clk              pixel clock
//   rst_n            synchronous active-low reset
//   per_frame_vsync  frame valid, active high
//   per_frame_href   line/pixel valid, active high
//   cfg              host write port (slave side)
//   nr_level         active Bayer NR level
//   img_mode         active output mode
//   color_curve_x    9 x 8-bit curve X; entry i at [8i+7:8i]
//   color_curve_y    9 x 5-bit curve Y; entry i at [5i+4:5i]
//   commit_pending   a commit is armed and waits for the next frame start
//   commit_done      one-cycle pulse when the active registers update
//   frame_cnt        frames started since reset; wraps
//   line_cnt         current active line index; saturates at 2047
//   frame_err        sticky geometry error
// ---------------------------------------------------------------------------
module isp_cfg_sequencer #(
  parameter int IMG_HDISP = 1920,
  parameter int IMG_VDISP = 1080
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      per_frame_vsync,
  input  logic                      per_frame_href,
  isp_cfg_sequencer_if.slave        cfg,
  output logic [3:0]                nr_level,
  output logic [3:0]                img_mode,
  output logic [71:0]               color_curve_x,
  output logic [44:0]               color_curve_y,
  output logic                      commit_pending,
  output logic                      commit_done,
  output logic [15:0]               frame_cnt,
  output logic [10:0]               line_cnt,
  output logic                      frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_VBLANK
  } state_t;

  // Reset curves, entry 8 in the most significant position.
  localparam logic [71:0] CURVE_X_RST = {8'd30, 8'd26, 8'd23, 8'd20, 8'd17,
                                         8'd13, 8'd10, 8'd6,  8'd3};
  localparam logic [44:0] CURVE_Y_RST = {5'd0,  5'd1,  5'd2,  5'd4,  5'd7,
                                         5'd13, 5'd19, 5'd26, 5'd30};

  // The line and pixel counters are 11 and 12 bits wide, so geometry that
  // does not fit is rejected at elaboration.
  if (IMG_HDISP < 1 || IMG_HDISP > 4095 || IMG_VDISP < 1 || IMG_VDISP > 2047) begin : g_bad_geometry
    $error("isp_cfg_sequencer: IMG_HDISP/IMG_VDISP out of range");
  end

  state_t      state_q;
  state_t      state_d;
  logic        vsync_q;
  logic        vsync_d;
  logic        href_q;
  logic        href_d;
  logic        vs_rise;
  logic        vs_fall;
  logic        href_fall;
  logic        frame_start;
  logic        accept;
  logic        cfg_ready_q;
  logic [3:0]  sh_nr_level;
  logic [3:0]  sh_img_mode;
  logic [71:0] sh_curve_x;
  logic [44:0] sh_curve_y;

  // Sync inputs are registered once, and a second stage gives edge
  // detection. During reset both stages load the live input. A sync level
  // that is already high when reset is released is therefore never taken
  // for an edge, so the in-flight frame is ignored.
  always_ff @(posedge clk) begin
    vsync_q <= per_frame_vsync;
    href_q  <= per_frame_href;
    vsync_d <= rst_n ? vsync_q : per_frame_vsync;
    href_d  <= rst_n ? href_q  : per_frame_href;
  end

  assign vs_rise     = vsync_q & ~vsync_d;
  assign vs_fall     = ~vsync_q & vsync_d;
  assign href_fall   = ~href_q & href_d;
  assign frame_start = vs_rise;
  assign accept      = cfg.cfg_valid & cfg_ready_q;
  assign cfg.cfg_ready = cfg_ready_q;

  // Ready is registered. It predicts next cycle's frame start from the raw
  // input and the first sync stage, so it drops for exactly that one cycle.
  // No host write can therefore coincide with the shadow-to-active copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b1;
    end else begin
      cfg_ready_q <= ~(per_frame_vsync & ~vsync_q);
    end
  end

  // Frame tracking state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. IDLE only leaves on a genuine rising edge, so a frame
  // already in progress at reset is skipped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (vs_rise) state_d = ST_FRAME;
      ST_FRAME:  if (vs_fall) state_d = ST_VBLANK;
      ST_VBLANK: if (vs_rise) state_d = ST_FRAME;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Shadow register file, written on every accepted beat. Addresses that
  // are not decoded here are accepted and have no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_nr_level <= 4'd0;
      sh_img_mode <= 4'd1;
      sh_curve_x  <= CURVE_X_RST;
      sh_curve_y  <= CURVE_Y_RST;
    end else if (accept) begin
      if (cfg.cfg_addr == 5'h00) sh_nr_level <= cfg.cfg_wdata[3:0];
      if (cfg.cfg_addr == 5'h01) sh_img_mode <= cfg.cfg_wdata[3:0];
      for (int i = 0; i < 9; i++) begin
        if (cfg.cfg_addr == 5'(i + 3))  sh_curve_x[8*i +: 8] <= cfg.cfg_wdata;
        if (cfg.cfg_addr == 5'(i + 12)) sh_curve_y[5*i +: 5] <= cfg.cfg_wdata[4:0];
      end
    end
  end

  // Commit path. An arm only sets a flag, so a repeated arm is harmless and
  // commits never queue. At frame start the whole shadow set moves at once.
  // Arm writes and frame start never share a cycle because ready is low
  // during frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nr_level       <= 4'd0;
      img_mode       <= 4'd1;
      color_curve_x  <= CURVE_X_RST;
      color_curve_y  <= CURVE_Y_RST;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      if (frame_start && commit_pending) begin
        nr_level       <= sh_nr_level;
        img_mode       <= sh_img_mode;
        color_curve_x  <= sh_curve_x;
        color_curve_y  <= sh_curve_y;
        commit_done    <= 1'b1;
        commit_pending <= 1'b0;
      end
      if (accept && cfg.cfg_addr == 5'h02) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Position counters. Lines are counted on href falling edges inside an
  // active frame only. The line index saturates rather than wrapping, so a
  // runaway frame still reports a large value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
      line_cnt  <= 11'd0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
      line_cnt  <= 11'd0;
    end else if (state_q == ST_FRAME && href_fall && line_cnt != 11'h7FF) begin
      line_cnt <= line_cnt + 11'd1;
    end
  end

`ifdef ISP_CFG_FRAME_CHECK_EN
  logic [11:0] pix_cnt;
  logic [11:0] lines_done;
  logic        line_bad;
  logic        frame_bad;
  logic        err_clear;

  // The completed line count includes a line whose end is seen in the same
  // cycle as the vsync falling edge.
  assign lines_done = {1'b0, line_cnt} + {11'd0, href_fall};
  assign line_bad   = (state_q == ST_FRAME) && href_fall && (pix_cnt != 12'(IMG_HDISP));
  assign frame_bad  = (state_q == ST_FRAME) && vs_fall && (lines_done != 12'(IMG_VDISP));
  assign err_clear  = accept && (cfg.cfg_addr == 5'h15) && cfg.cfg_wdata[0];

  // Pixel counter. It counts registered href-high cycles and restarts after
  // each line end. At the falling edge it still holds the finished line's
  // length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt <= 12'd0;
    end else if (href_fall) begin
      pix_cnt <= 12'd0;
    end else if (href_q && pix_cnt != 12'hFFF) begin
      pix_cnt <= pix_cnt + 12'd1;
    end
  end

  // Sticky error flag. A new error in the same cycle as a clear wins, so an
  // error is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (line_bad || frame_bad) begin
      frame_err <= 1'b1;
    end else if (err_clear) begin
      frame_err <= 1'b0;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
